// File: rtl/usb_pkt_router_pkg.sv
// Shared constants, header field layout and FSM state type for the USB packet router.
package usb_router_pkg;

  localparam logic [31:0] HDR_MASK    = 32'hFF0000FF;
  localparam logic [31:0] HDR_TAG     = 32'hFF0000AA;
  localparam logic [7:0]  MODE_SPLIT  = 8'h00;
  localparam logic [7:0]  MODE_DIRECT = 8'h01;

  typedef enum logic [1:0] {IDLE, FILL, DROP, DRAIN} state_e;

  // Bits [23:8] of a header word
  typedef struct packed {
    logic [7:0] mode;
    logic [7:0] base;
  } hdr_fields_t;

  function automatic logic is_hdr(input logic [31:0] w);
    return (w & HDR_MASK) == HDR_TAG;
  endfunction

endpackage

// File: rtl/usb_pkt_router_if.sv
// Ingress word stream and egress sample-RAM write stream of the packet router.
interface usb_pkt_router_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 24
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [NUM_CH-1:0] out_wren;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_wren
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_wren
  );
endinterface

// File: rtl/usb_pkt_router_pkt_buf_ram.sv
// Simple dual-port payload buffer, single clock, registered read port.
module pkt_buf_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/usb_pkt_router.sv
// Buffers one tagged USB packet and replays it to per-channel sample RAMs.
// Optional packet/error statistics counters: ROUTER_STATS_EN.
module usb_pkt_router
  import usb_router_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned NUM_CH  = 24,
  parameter int unsigned SEG_LEN = 32
) (
  input  logic              wrclock,
  input  logic              rst_n,
  usb_pkt_router_if.slave   bus,
  output logic              err_hdr,
  output logic              err_ovf,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SW = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
  localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);

  state_e         state_q, state_d;
  logic           direct_q, direct_d;
  logic [CW-1:0]  base_q, base_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    len_q, len_d;
  logic           drain_pend_q, drain_pend_d;
  logic           err_hdr_d, err_ovf_d;
  logic           wr_en_c;

  hdr_fields_t    hdr_c;
  logic           hdr_ok_c;
  logic           in_acc_c;

  logic [AW:0]    rd_ptr_q;
  logic [CW-1:0]  ch_q;
  logic [SW-1:0]  seg_q;
  logic           rd_vld_q;
  logic [CW-1:0]  rd_ch_q;
  logic           rd_last_q;
  logic [DATA_W-1:0] ram_q;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [NUM_CH-1:0] out_wren_q;
  logic              out_last_q;

  logic advance_c, load_c, issue_c, out_hs_c;

  assign bus.in_ready  = (state_q != DRAIN);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_wren  = out_wren_q;

  assign in_acc_c = bus.in_valid && (state_q != DRAIN);
  assign hdr_c    = hdr_fields_t'(bus.in_data[23:8]);
  assign hdr_ok_c = ((hdr_c.mode == MODE_SPLIT) || (hdr_c.mode == MODE_DIRECT)) &&
                    (32'(hdr_c.base) < NUM_CH);

  // Read pipeline: RAM output stage feeds a one-entry output register
  assign advance_c = !out_valid_q || bus.out_ready;
  assign load_c    = rd_vld_q && advance_c;
  assign out_hs_c  = out_valid_q && bus.out_ready;
  assign issue_c   = (state_q == DRAIN) && (rd_ptr_q != len_q) && (!rd_vld_q || load_c);

  always_ff @(posedge wrclock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      direct_q     <= 1'b0;
      base_q       <= '0;
      wr_ptr_q     <= '0;
      len_q        <= '0;
      drain_pend_q <= 1'b0;
      err_hdr      <= 1'b0;
      err_ovf      <= 1'b0;
    end else begin
      state_q      <= state_d;
      direct_q     <= direct_d;
      base_q       <= base_d;
      wr_ptr_q     <= wr_ptr_d;
      len_q        <= len_d;
      drain_pend_q <= drain_pend_d;
      err_hdr      <= err_hdr_d;
      err_ovf      <= err_ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    direct_d     = direct_q;
    base_d       = base_q;
    wr_ptr_d     = wr_ptr_q;
    len_d        = len_q;
    drain_pend_d = drain_pend_q;
    err_hdr_d    = 1'b0;
    err_ovf_d    = 1'b0;
    wr_en_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_acc_c && is_hdr(bus.in_data[31:0])) begin
          drain_pend_d = 1'b0;
          if (hdr_ok_c) begin
            direct_d = (hdr_c.mode == MODE_DIRECT);
            base_d   = CW'(hdr_c.base);
            wr_ptr_d = '0;
            if (!bus.in_last) state_d = FILL;
          end else begin
            err_hdr_d = 1'b1;
            if (!bus.in_last) state_d = DROP;
          end
        end
      end
      FILL: begin
        if (in_acc_c) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (bus.in_last) begin
            len_d   = {1'b0, wr_ptr_q} + (AW+1)'(1);
            state_d = DRAIN;
          end else if (wr_ptr_q == AW'(DEPTH-1)) begin
            err_ovf_d    = 1'b1;
            len_d        = LEN_FULL;
            drain_pend_d = 1'b1;
            state_d      = DROP;
          end
        end
      end
      DROP: begin
        if (in_acc_c && bus.in_last) begin
          state_d      = drain_pend_q ? DRAIN : IDLE;
          drain_pend_d = 1'b0;
        end
      end
      DRAIN: begin
        if (out_hs_c && out_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  pkt_buf_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
    .clk   (wrclock),
    .we    (wr_en_c),
    .waddr (wr_ptr_q),
    .wdata (bus.in_data),
    .re    (issue_c),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_q)
  );

  // Replay address and channel tracking; channel advances once per SEG_LEN words in split mode
  always_ff @(posedge wrclock or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      ch_q        <= '0;
      seg_q       <= '0;
      rd_vld_q    <= 1'b0;
      rd_ch_q     <= '0;
      rd_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_wren_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (state_q != DRAIN) begin
        rd_ptr_q <= '0;
        ch_q     <= base_q;
        seg_q    <= '0;
        rd_vld_q <= 1'b0;
      end else begin
        if (issue_c) begin
          rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
          rd_ch_q   <= ch_q;
          rd_last_q <= (rd_ptr_q == len_q - (AW+1)'(1));
          if (!direct_q) begin
            if (seg_q == SW'(SEG_LEN-1)) begin
              seg_q <= '0;
              ch_q  <= (ch_q == CW'(NUM_CH-1)) ? '0 : ch_q + CW'(1);
            end else begin
              seg_q <= seg_q + SW'(1);
            end
          end
        end
        rd_vld_q <= issue_c || (rd_vld_q && !load_c);
      end
      if (advance_c) begin
        out_valid_q <= load_c;
        if (load_c) begin
          out_data_q <= ram_q;
          out_wren_q <= NUM_CH'(1) << rd_ch_q;
          out_last_q <= rd_last_q;
        end else begin
          out_wren_q <= '0;
        end
      end
    end
  end

`ifdef ROUTER_STATS_EN
  logic pkt_done_c;
  assign pkt_done_c = (state_q == DRAIN) && out_hs_c && out_last_q;

  // Saturating statistics
  always_ff @(posedge wrclock or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (pkt_done_c && (pkt_cnt != 16'hFFFF)) pkt_cnt <= pkt_cnt + 16'd1;
      if ((err_hdr || err_ovf) && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign pkt_cnt = 16'd0;
  assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_usb_pkt_router.sv
// Randomised self-checking bench for usb_pkt_router against a packet-level expectation queue.
module tb_usb_pkt_router;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned NUM_CH  = 24;
  localparam int unsigned SEG_LEN = 32;

  logic        wrclock = 1'b0;
  logic        rst_n;
  logic        err_hdr, err_ovf;
  logic [15:0] pkt_cnt, err_cnt;

  always #5 wrclock = ~wrclock;

  usb_pkt_router_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

  usb_pkt_router #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .SEG_LEN(SEG_LEN)) dut (
    .wrclock (wrclock),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .err_hdr (err_hdr),
    .err_ovf (err_ovf),
    .pkt_cnt (pkt_cnt),
    .err_cnt (err_cnt)
  );

  typedef struct {
    logic [31:0]       d;
    logic [NUM_CH-1:0] w;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;
  int   hs_cnt = 0, hdr_pulses = 0, ovf_pulses = 0;
  int   m_pkts = 0, m_errs = 0;
  int   rdy_mode = 0;
  bit   stall_q = 0;
  logic [31:0]       held_d;
  logic [NUM_CH-1:0] held_w;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // Channel of payload word k from the routing rules
  function automatic logic [NUM_CH-1:0] chan_mask(input int base, input bit direct, input int k);
    logic [NUM_CH-1:0] m;
    int ch;
    ch = direct ? base : (base + k / SEG_LEN) % NUM_CH;
    m = '0;
    m[ch] = 1'b1;
    return m;
  endfunction

  function automatic logic [15:0] exp_cnt(input int v);
`ifdef ROUTER_STATS_EN
    return (v > 65535) ? 16'hFFFF : 16'(v);
`else
    return 16'd0 & 16'(v);
`endif
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge wrclock);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output compare against the expectation queue
  always @(negedge wrclock) begin
    if (!rst_n) begin
      stall_q = 0;
    end else begin
      if (stall_q)
        chk(bus.out_valid && bus.out_data == held_d && bus.out_wren == held_w, "stall_hold",
            {bus.out_wren, bus.out_data}, {held_w, held_d});
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_out", bus.out_data, 0);
        end else begin
          chk(bus.out_data == exp_q[0].d, "out_data", bus.out_data, exp_q[0].d);
          chk(bus.out_wren == exp_q[0].w, "out_wren", bus.out_wren, exp_q[0].w);
          if (bus.out_ready) begin
            exp_q.delete(0);
            hs_cnt++;
          end
        end
      end else begin
        chk(bus.out_wren == '0, "wren_idle", bus.out_wren, 0);
      end
      stall_q = bus.out_valid && !bus.out_ready;
      held_d  = bus.out_data;
      held_w  = bus.out_wren;
      if (err_hdr) hdr_pulses++;
      if (err_ovf) ovf_pulses++;
      if (err_hdr && err_ovf) chk(1'b0, "err_both", 1, 0);
    end
  end

  task automatic send_word(input logic [31:0] d, input bit last);
    bit ok;
    ok = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge wrclock);
      if (bus.in_ready) ok = 1;
      @(posedge wrclock);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) chk(1'b0, "in_ready_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int t = 0; t < 6000 && !done; t++) begin
      @(negedge wrclock);
      if (exp_q.size() == 0 && !bus.out_valid && bus.in_ready) done = 1;
    end
    if (!done) chk(1'b0, "drain_timeout", exp_q.size(), 0);
  endtask

  task automatic run_pkt(input logic [31:0] hdr, input int n, input bit hdr_last,
                         input bit seq_data, input bit chk_lat, input int gap_pct);
    logic [7:0]  mode;
    int          base, len, h0, o0;
    bit          good, ovf;
    logic [31:0] pl[$];
    exp_t        e;
    mode = hdr[23:16];
    base = int'(hdr[15:8]);
    good = (mode <= 8'd1) && (base < NUM_CH);
    ovf  = good && !hdr_last && (n > DEPTH);
    for (int k = 0; k < n; k++) pl.push_back(seq_data ? 32'(k) : $urandom());
    len = (good && !hdr_last) ? ((n > DEPTH) ? DEPTH : n) : 0;
    for (int k = 0; k < len; k++) begin
      e.d = pl[k];
      e.w = chan_mask(base, mode == 8'd1, k);
      exp_q.push_back(e);
    end
    h0 = hdr_pulses;
    o0 = ovf_pulses;
    send_word(hdr, hdr_last);
    if (!hdr_last) begin
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 99) < gap_pct) begin
          @(posedge wrclock);
          #1;
        end
        send_word(pl[k], k == n - 1);
      end
    end
    if (chk_lat) begin
      @(negedge wrclock);
      chk(!bus.in_ready, "in_ready_drain", bus.in_ready, 0);
      chk(!bus.out_valid, "lat_edge0", bus.out_valid, 0);
      @(negedge wrclock);
      chk(!bus.out_valid, "lat_edge1", bus.out_valid, 0);
      @(negedge wrclock);
      chk(bus.out_valid, "lat_edge2", bus.out_valid, 1);
    end
    wait_drain();
    repeat (3) @(posedge wrclock);
    #1;
    if (good && !hdr_last) m_pkts++;
    if (!good) m_errs++;
    if (ovf) m_errs++;
    chk(hdr_pulses - h0 == int'(!good), "err_hdr_pulses", hdr_pulses - h0, int'(!good));
    chk(ovf_pulses - o0 == int'(ovf), "err_ovf_pulses", ovf_pulses - o0, int'(ovf));
    chk(pkt_cnt == exp_cnt(m_pkts), "pkt_cnt", pkt_cnt, exp_cnt(m_pkts));
    chk(err_cnt == exp_cnt(m_errs), "err_cnt", err_cnt, exp_cnt(m_errs));
  endtask

  initial begin
    bit          bad, hl;
    int          n;
    logic [7:0]  mode, base;
    rst_n        = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge wrclock);
    #1;
    chk(bus.in_ready == 1'b1, "rst_in_ready", bus.in_ready, 1);
    chk(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
    chk(bus.out_wren == '0, "rst_out_wren", bus.out_wren, 0);
    chk(bus.out_data == '0, "rst_out_data", bus.out_data, 0);
    chk(!err_hdr && !err_ovf, "rst_err", {err_hdr, err_ovf}, 0);
    chk(pkt_cnt == 16'd0 && err_cnt == 16'd0, "rst_cnt", {pkt_cnt, err_cnt}, 0);
    #1 rst_n = 1'b1;
    @(posedge wrclock);
    #1;

    chk(chan_mask(1, 0, 0) == 24'h000002, "model_split_seg0", chan_mask(1, 0, 0), 24'h000002);
    chk(chan_mask(1, 0, 32) == 24'h000004, "model_split_seg1", chan_mask(1, 0, 32), 24'h000004);
    chk(chan_mask(23, 0, 32) == 24'h000001, "model_wrap", chan_mask(23, 0, 32), 24'h000001);
    chk(chan_mask(23, 1, 4) == 24'h800000, "model_direct", chan_mask(23, 1, 4), 24'h800000);

    // Split base 1, 64 sequential words, latency probe
    rdy_mode = 0;
    run_pkt(32'hFF0001AA, 64, 0, 1, 1, 0);
`ifdef ROUTER_STATS_EN
    chk(pkt_cnt == 16'd1, "pkt_cnt_first", pkt_cnt, 1);
`else
    chk(pkt_cnt == 16'd0, "pkt_cnt_first", pkt_cnt, 0);
`endif

    // Direct base 23 with alternating backpressure
    rdy_mode = 1;
    run_pkt(32'hFF0117AA, 5, 0, 0, 0, 0);

    // Split base 23 wraps to channel 0
    rdy_mode = 0;
    run_pkt(32'hFF0017AA, 40, 0, 0, 0, 0);

    // Overflow: 300 words, 256 replayed
    run_pkt(32'hFF0003AA, 300, 0, 0, 0, 0);

    // Reset at drained word 10
    begin
      exp_t e;
      int   h0;
      for (int k = 0; k < 64; k++) begin
        e.d = 32'(k) ^ 32'h5A5A0000;
        e.w = chan_mask(2, 0, k);
        exp_q.push_back(e);
      end
      h0 = hs_cnt;
      send_word(32'hFF0002AA, 0);
      for (int k = 0; k < 64; k++) send_word(32'(k) ^ 32'h5A5A0000, k == 63);
      for (int t = 0; t < 500 && hs_cnt - h0 < 10; t++) @(negedge wrclock);
      chk(hs_cnt - h0 == 10, "reset_reach", hs_cnt - h0, 10);
      @(posedge wrclock);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      m_pkts = 0;
      m_errs = 0;
      #1;
      chk(bus.out_valid == 1'b0, "rst_mid_valid", bus.out_valid, 0);
      chk(bus.in_ready == 1'b1, "rst_mid_ready", bus.in_ready, 1);
      chk(bus.out_wren == '0, "rst_mid_wren", bus.out_wren, 0);
      repeat (2) @(posedge wrclock);
      #2;
      rst_n = 1'b1;
      @(posedge wrclock);
      #1;
    end
    run_pkt(32'hFF0005AA, 20, 0, 0, 0, 0);

    // Bad mode and out-of-range base
    run_pkt(32'hFF0205AA, 3, 0, 0, 0, 0);
    run_pkt(32'hFF0020AA, 2, 0, 0, 0, 0);
`ifdef ROUTER_STATS_EN
    chk(err_cnt == 16'd2, "err_cnt_bad_hdrs", err_cnt, 2);
`else
    chk(err_cnt == 16'd0, "err_cnt_bad_hdrs", err_cnt, 0);
`endif

    // Empty packet: header carrying in_last
    run_pkt(32'hFF0004AA, 0, 1, 0, 0, 0);

    // Randomised traffic
    for (int p = 0; p < 40; p++) begin
      rdy_mode = $urandom_range(0, 2);
      bad  = ($urandom_range(0, 9) == 0);
      mode = bad ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
      base = 8'($urandom_range(0, 31));
      bad  = bad || (base >= 8'(NUM_CH));
      hl   = !bad && ($urandom_range(0, 9) == 0);
      n    = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 262) : $urandom_range(1, 70);
      if ($urandom_range(0, 2) == 0) send_word({$urandom_range(0, 65535), 16'h1255}, 1'b0);
      run_pkt({8'hFF, mode, base, 8'hAA}, n, hl, 0, 0, 20);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
